// File: rtl/dyser_input_port.sv
// dyser_input_port: host-to-fabric injection port; buffers host words in a FIFO
// and forwards them as valid-tagged words under one-bit credit flow control.
`ifndef PATH_WIDTH
`define PATH_WIDTH 32
`endif
module dyser_input_port #(
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = 2,
    parameter int PORT_ID    = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            conf_en,
    input  logic [`PATH_WIDTH-1:0]          host_data,
    input  logic                            host_valid,
    output logic                            host_ready,
    output logic [`PATH_WIDTH:0]            d_out,
    input  logic                            c_in,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [$clog2(CREDITS):0]        credit_cnt,
    output logic                            credit_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CREDITS) + 1;
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CREDITS < 1 || PORT_ID < 0) begin : g_bad_param
        $error("dyser_input_port: illegal parameters");
    end
    typedef enum logic {S_RUN, S_CONF} state_t;
    state_t                 r_state, w_next;
    logic [`PATH_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr, r_rd;
    logic [AW:0]            r_count;
    logic [CW-1:0]          r_credit;
    logic                   r_err;
    logic [`PATH_WIDTH:0]   r_dout;
    logic                   w_full, w_empty, w_push, w_pop, w_send_en, w_conf, w_ret;
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (r_state == S_RUN && conf_en)   w_next = S_CONF;
        if (r_state == S_CONF && !conf_en) w_next = S_RUN;
    end
    always_comb begin
        w_send_en = (r_state == S_RUN) && !conf_en;
        w_conf    = (r_state == S_CONF);
    end
    assign w_full     = r_count == (AW+1)'(FIFO_DEPTH);
    assign w_empty    = r_count == '0;
    assign host_ready = !rst && !w_full;
    assign w_push     = host_valid && host_ready;
    assign w_pop      = w_send_en && !w_empty && r_credit != '0;
    // c_in is only honoured outside the configuration phase
    assign w_ret      = c_in && !w_conf;
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= host_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr     <= '0;
            r_rd     <= '0;
            r_count  <= '0;
            r_credit <= CW'(CREDITS);
            r_err    <= 1'b0;
            r_dout   <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_dout  <= w_pop ? {1'b1, r_mem[r_rd]} : '0;
            if (w_conf)
                r_credit <= CW'(CREDITS);
            else if (w_ret && !w_pop && r_credit == CW'(CREDITS))
                r_err <= 1'b1;
            else if (w_ret && !w_pop)
                r_credit <= r_credit + CW'(1);
            else if (w_pop && !w_ret)
                r_credit <= r_credit - CW'(1);
        end
    end
    assign d_out      = r_dout;
    assign fifo_count = r_count;
    assign credit_cnt = r_credit;
    assign credit_err = r_err;
endmodule

// File: tb/tb_dyser_input_port.sv
// tb_dyser_input_port: table-driven per-cycle vectors plus hand-written
// sequences for streaming, configuration freeze and mid-stream reset.
`ifndef PATH_WIDTH
`define PATH_WIDTH 32
`endif
module tb_dyser_input_port;
    localparam int PW = `PATH_WIDTH;
    logic          clk = 1'b0;
    logic          rst = 1'b1, conf_en = 1'b0, host_valid = 1'b0, c_in = 1'b0;
    logic [PW-1:0] host_data = '0;
    logic          host_ready, credit_err;
    logic [PW:0]   d_out;
    logic [2:0]    fifo_count;
    logic [1:0]    credit_cnt;
    int            tests = 0, fails = 0;

    dyser_input_port #(.FIFO_DEPTH(4), .CREDITS(2), .PORT_ID(0)) dut (
        .clk(clk), .rst(rst), .conf_en(conf_en), .host_data(host_data),
        .host_valid(host_valid), .host_ready(host_ready), .d_out(d_out),
        .c_in(c_in), .fifo_count(fifo_count), .credit_cnt(credit_cnt),
        .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst, conf, hv;
        logic [PW-1:0] hd;
        logic          cin, dv;
        logic [PW-1:0] dd;
        logic [2:0]    fc;
        logic [1:0]    cc;
        logic          hr, err;
    } vec_t;

    function automatic vec_t v(logic r, logic cf, logic hv, logic [PW-1:0] hd, logic ci,
                               logic dv, logic [PW-1:0] dd, logic [2:0] fc, logic [1:0] cc,
                               logic hr, logic er);
        vec_t t;
        t.rst = r; t.conf = cf; t.hv = hv; t.hd = hd; t.cin = ci;
        t.dv = dv; t.dd = dd; t.fc = fc; t.cc = cc; t.hr = hr; t.err = er;
        return t;
    endfunction

    task automatic check(string name, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(logic r, logic cf, logic hv, logic [PW-1:0] hd, logic ci);
        rst = r; conf_en = cf; host_valid = hv; host_data = hd; c_in = ci;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[26];
    int   first_v, last_v, rcv, snt, got;

    initial begin
        // rst conf hv data cin | dv data fc cc hr err (outputs after the edge)
        tbl[0]  = v(1,0,0,'h0,0, 0,'h0,0,2,0,0);
        tbl[1]  = v(1,0,0,'h0,0, 0,'h0,0,2,0,0);
        tbl[2]  = v(0,0,0,'h0,0, 0,'h0,0,2,1,0);
        tbl[3]  = v(0,0,1,'hA,0, 0,'h0,1,2,1,0);
        tbl[4]  = v(0,0,1,'hB,0, 1,'hA,1,1,1,0);
        tbl[5]  = v(0,0,1,'hC,0, 1,'hB,1,0,1,0);
        tbl[6]  = v(0,0,0,'h0,0, 0,'h0,1,0,1,0);
        tbl[7]  = v(0,0,0,'h0,0, 0,'h0,1,0,1,0);
        tbl[8]  = v(0,0,0,'h0,1, 0,'h0,1,1,1,0);
        tbl[9]  = v(0,0,0,'h0,0, 1,'hC,0,0,1,0);
        tbl[10] = v(0,0,1,'h1,0, 0,'h0,1,0,1,0);
        tbl[11] = v(0,0,1,'h2,0, 0,'h0,2,0,1,0);
        tbl[12] = v(0,0,1,'h3,0, 0,'h0,3,0,1,0);
        tbl[13] = v(0,0,1,'h4,0, 0,'h0,4,0,0,0);
        tbl[14] = v(0,0,1,'h5,0, 0,'h0,4,0,0,0);
        tbl[15] = v(0,0,0,'h0,1, 0,'h0,4,1,0,0);
        tbl[16] = v(0,0,0,'h0,1, 1,'h1,3,1,1,0);
        tbl[17] = v(0,0,0,'h0,1, 1,'h2,2,1,1,0);
        tbl[18] = v(0,0,0,'h0,0, 1,'h3,1,0,1,0);
        tbl[19] = v(0,0,0,'h0,1, 0,'h0,1,1,1,0);
        tbl[20] = v(0,0,0,'h0,1, 1,'h4,0,1,1,0);
        tbl[21] = v(0,0,0,'h0,1, 0,'h0,0,2,1,0);
        tbl[22] = v(0,0,0,'h0,1, 0,'h0,0,2,1,1);
        tbl[23] = v(0,0,0,'h0,0, 0,'h0,0,2,1,1);
        tbl[24] = v(1,0,0,'h0,0, 0,'h0,0,2,0,0);
        tbl[25] = v(0,0,0,'h0,0, 0,'h0,0,2,1,0);

        for (int i = 0; i < 26; i++) begin
            step(tbl[i].rst, tbl[i].conf, tbl[i].hv, tbl[i].hd, tbl[i].cin);
            check($sformatf("v%0d.valid", i), d_out[PW], tbl[i].dv);
            check($sformatf("v%0d.data", i), d_out[PW-1:0], tbl[i].dd);
            check($sformatf("v%0d.fifo_count", i), fifo_count, tbl[i].fc);
            check($sformatf("v%0d.credit_cnt", i), credit_cnt, tbl[i].cc);
            check($sformatf("v%0d.host_ready", i), host_ready, tbl[i].hr);
            check($sformatf("v%0d.credit_err", i), credit_err, tbl[i].err);
        end

        // 100-word stream, credit returned for every word seen on d_out
        snt = 0; rcv = 0; first_v = -1; last_v = -1;
        for (int cyc = 0; cyc < 300 && rcv < 100; cyc++) begin
            logic push;
            rst = 0; conf_en = 0;
            c_in = d_out[PW];
            host_valid = snt < 100;
            host_data = PW'(32'h1000 + snt);
            push = host_valid && host_ready;
            @(posedge clk);
            #1;
            if (push) snt++;
            if (d_out[PW]) begin
                check("stream.data", d_out[PW-1:0], 32'h1000 + rcv);
                if (rcv > 0) check("stream.credit_cnt", credit_cnt, 1);
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                rcv++;
            end
        end
        check("stream.count", rcv, 100);
        check("stream.back_to_back", last_v - first_v, 99);
        step(0, 0, 0, '0, d_out[PW]);
        step(0, 0, 0, '0, d_out[PW]);
        check("stream.credit_restored", credit_cnt, 2);
        check("stream.no_err", credit_err, 0);

        // configuration freeze with two words buffered and no credits
        step(0, 0, 1, 'h21, 0);
        step(0, 0, 1, 'h22, 0);
        step(0, 0, 1, 'h23, 0);
        step(0, 0, 1, 'h24, 0);
        step(0, 0, 0, '0, 0);
        check("conf.pre_fc", fifo_count, 2);
        check("conf.pre_cc", credit_cnt, 0);
        step(0, 1, 0, '0, 0);
        check("conf.enter_no_send", d_out[PW], 0);
        step(0, 1, 0, '0, 0);
        check("conf.cc_forced", credit_cnt, 2);
        check("conf.fc_kept", fifo_count, 2);
        step(0, 1, 0, '0, 1);
        check("conf.cin_ignored_cc", credit_cnt, 2);
        check("conf.cin_ignored_err", credit_err, 0);
        check("conf.no_send", d_out[PW], 0);
        got = 0;
        for (int cyc = 0; cyc < 6 && got < 2; cyc++) begin
            step(0, 0, 0, '0, 0);
            if (got == 1) begin
                check("conf.second_b2b", d_out[PW], 1);
                check("conf.second_data", d_out[PW-1:0], 'h24);
                got = 2;
            end else if (d_out[PW]) begin
                check("conf.first_data", d_out[PW-1:0], 'h23);
                got = 1;
            end
        end
        check("conf.words_sent", got, 2);

        // reset while a word is on d_out and another is buffered
        step(0, 0, 1, 'h31, 0);
        step(0, 0, 1, 'h32, 0);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 0);
        check("rst_mid.valid_before", d_out[PW], 1);
        check("rst_mid.data_before", d_out[PW-1:0], 'h31);
        step(1, 0, 1, 'h33, 0);
        check("rst_mid.valid", d_out[PW], 0);
        check("rst_mid.fc", fifo_count, 0);
        check("rst_mid.cc", credit_cnt, 2);
        check("rst_mid.hr", host_ready, 0);
        step(0, 0, 0, '0, 0);
        check("rst_mid.no_send_after", d_out[PW], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
